// File: rtl/sat_accum_fsm.sv
// Multi-channel unsigned burst accumulator: sums tagged beats per channel, then drains them in channel order.
// Optional macro SAT_ACCUM_SATURATE_EN clamps on carry-out instead of wrapping.
module sat_accum_fsm #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int COUNT_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [COUNT_W-1:0]          len,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [$clog2(CHANNELS)-1:0] in_ch,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [$clog2(CHANNELS)-1:0] out_ch,
  output logic [CHANNELS-1:0]         ovf,
  output logic                        busy,
  output logic                        done
);

  localparam int CH_W = $clog2(CHANNELS);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_reg;
  logic [COUNT_W-1:0]   remaining_reg;
  logic [CH_W-1:0]      drain_idx_reg;
  logic                 in_ready_reg;
  logic                 out_valid_reg;
  logic                 busy_reg;
  logic                 done_reg;

  logic                 clear_all;
  logic                 beat_fire;
  logic                 drain_fire;
  logic [WIDTH-1:0]     acc_view [CHANNELS];

  assign clear_all  = (state_reg == IDLE) && start;
  assign beat_fire  = (state_reg == ACCUM) && in_valid && in_ready_reg;
  assign drain_fire = (state_reg == DRAIN) && out_valid_reg && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      drain_idx_reg <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            remaining_reg <= len;
            busy_reg      <= 1'b1;
            if (len != '0) begin
              state_reg    <= ACCUM;
              in_ready_reg <= 1'b1;
            end else begin
              state_reg     <= DRAIN;
              out_valid_reg <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (beat_fire) begin
            remaining_reg <= remaining_reg - COUNT_W'(1);
            // The last beat closes the input port; draining starts next cycle.
            if (remaining_reg == COUNT_W'(1)) begin
              state_reg     <= DRAIN;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_fire) begin
            if (drain_idx_reg == LAST_CH) begin
              drain_idx_reg <= '0;
              out_valid_reg <= 1'b0;
              done_reg      <= 1'b1;
              state_reg     <= DONE;
            end else begin
              drain_idx_reg <= drain_idx_reg + CH_W'(1);
            end
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg     <= IDLE;
          remaining_reg <= '0;
          drain_idx_reg <= '0;
          in_ready_reg  <= 1'b0;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          done_reg      <= 1'b0;
        end
      endcase
    end
  end

  // One accumulator per channel; an in_ch beyond CHANNELS-1 matches none and is only counted.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [WIDTH-1:0] acc_reg;
      logic             ovf_reg;
      logic [WIDTH:0]   sum_next;
      logic [WIDTH-1:0] acc_next;
      logic             hit;

      assign hit      = beat_fire && (in_ch == CH_W'(gi));
      assign sum_next = {1'b0, acc_reg} + {1'b0, in_data};
`ifdef SAT_ACCUM_SATURATE_EN
      assign acc_next = sum_next[WIDTH] ? {WIDTH{1'b1}} : sum_next[WIDTH-1:0];
`else
      assign acc_next = sum_next[WIDTH-1:0];
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_reg <= '0;
          ovf_reg <= 1'b0;
        end else if (clear_all) begin
          acc_reg <= '0;
          ovf_reg <= 1'b0;
        end else if (hit) begin
          acc_reg <= acc_next;
          if (sum_next[WIDTH]) begin
            ovf_reg <= 1'b1;
          end
        end
      end

      assign acc_view[gi] = acc_reg;
      assign ovf[gi]      = ovf_reg;
    end
  endgenerate

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_ch    = drain_idx_reg;
  assign out_data  = out_valid_reg ? acc_view[drain_idx_reg] : '0;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_sat_accum_fsm.sv
// Directed bench for sat_accum_fsm (WIDTH=8, CHANNELS=4) with a per-cycle reference model of sums and drain order.
module tb_sat_accum_fsm;

  localparam int W = 8;
  localparam int C = 4;
  localparam int CW = 8;
`ifdef SAT_ACCUM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [1:0]    in_ch = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [1:0]    out_ch;
  logic [C-1:0]  ovf;
  logic          busy;
  logic          done;

  sat_accum_fsm #(.WIDTH(W), .CHANNELS(C), .COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: what the outputs must be given the handshakes seen so far
  int         m_acc [C];
  logic [C-1:0] m_ovf = '0;
  int         m_len = 0, m_beats = 0, m_drains = 0;
  bit         m_active = 1'b0;
  int         cyc = 0;
  int         start_cyc = 0, first_ov_cyc = 0;
  bit         seen_ov = 1'b0, saw_in_ready = 1'b0;
  int         done_cnt = 0;
  bit         prev_stall = 1'b0;
  logic [1:0] prev_ch;
  logic [W-1:0] prev_data;
  int         cap_ch[$];
  int         cap_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < C; i++) m_acc[i] = 0;
      m_ovf = '0; m_len = 0; m_beats = 0; m_drains = 0;
      m_active = 1'b0; prev_stall = 1'b0;
    end else begin
      chk("busy", busy, m_active);
      chk("ovf", ovf, m_ovf);
      if (in_ready) begin
        saw_in_ready = 1'b1;
        chk("in_ready_window", (m_active && m_beats < m_len), 1);
      end
      if (prev_stall) chk("hold_valid", out_valid, 1);
      if (out_valid) begin
        if (!seen_ov) begin
          seen_ov = 1'b1;
          first_ov_cyc = cyc;
        end
        chk("beats_before_drain", m_beats, m_len);
        chk("out_ch", out_ch, m_drains);
        if (m_drains < C) chk("out_data", out_data, m_acc[m_drains]);
        else chk("drain_overrun", m_drains, C - 1);
        if (prev_stall) begin
          chk("hold_ch", out_ch, prev_ch);
          chk("hold_data", out_data, prev_data);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_ch = out_ch;
      prev_data = out_data;
      if (done) begin
        chk("done_after_drain", m_drains, C);
        done_cnt++;
        m_active = 1'b0;
      end
      if (in_valid && in_ready) begin
        if (int'(in_ch) < C) begin
          int s;
          s = m_acc[in_ch] + int'(in_data);
          if (s > 255) begin
            m_ovf[in_ch] = 1'b1;
            s = SAT ? 255 : s - 256;
          end
          m_acc[in_ch] = s;
        end
        m_beats++;
      end
      if (out_valid && out_ready) begin
        cap_ch.push_back(int'(out_ch));
        cap_data.push_back(int'(out_data));
        m_drains++;
      end
      if (start && !busy) begin
        for (int i = 0; i < C; i++) m_acc[i] = 0;
        m_ovf = '0; m_len = int'(len); m_beats = 0; m_drains = 0;
        m_active = 1'b1; start_cyc = cyc; seen_ov = 1'b0; saw_in_ready = 1'b0;
        cap_ch.delete();
        cap_data.delete();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_burst(input int n);
    start = 1'b1;
    len = CW'(n);
    step();
    start = 1'b0;
  endtask

  task automatic send(input int ch, input int d);
    in_ch = 2'(ch);
    in_data = W'(d);
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (in_ready) begin
        step();
        in_valid = 1'b0;
        return;
      end
      step();
    end
    total++; bad++;
    $display("FAIL send_timeout: got in_ready=0 expected in_ready=1 within 50 cycles");
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < 100; k++) begin
      if (done_cnt > d0) return;
      step();
    end
    total++; bad++;
    $display("FAIL done_timeout: got no done expected done within 100 cycles");
  endtask

  task automatic chk_drain(input string tag, input int d0, input int d1, input int d2, input int d3);
    int exp_d [4];
    exp_d = '{d0, d1, d2, d3};
    chk({tag, "_count"}, cap_data.size(), 4);
    if (cap_data.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("%s_ch%0d", tag, i), cap_ch[i], i);
        chk($sformatf("%s_data%0d", tag, i), cap_data[i], exp_d[i]);
      end
    end
  endtask

  initial begin
    int d0;
    for (int i = 0; i < C; i++) m_acc[i] = 0;

    // Reset values
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    step();

    // Reset in the middle of ACCUM
    begin_burst(4);
    send(2, 200);
    send(2, 200);
    chk("mid_ovf_set", ovf, 4'b0100);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_ovf", ovf, 0);
    step();
    rst_n = 1'b1;
    step();

    // Full-rate burst
    d0 = done_cnt;
    begin_burst(4);
    send(0, 10); send(1, 20); send(0, 5); send(3, 1);
    wait_done();
    step(); step();
    chk_drain("basic", 15, 20, 0, 1);
    chk("basic_latency", first_ov_cyc - start_cyc, 5);
    chk("basic_done_once", done_cnt - d0, 1);
    chk("basic_ovf", ovf, 0);
    chk("basic_idle_busy", busy, 0);

    // Carry-out on channel 2
    begin_burst(2);
    send(2, 200); send(2, 100);
    wait_done();
    step();
    chk_drain("carry", 0, 0, SAT ? 255 : 44, 0);
    chk("carry_ovf", ovf, 4'b0100);

    // Empty burst
    begin_burst(0);
    wait_done();
    step();
    chk_drain("empty", 0, 0, 0, 0);
    chk("empty_no_in_ready", saw_in_ready, 0);
    chk("empty_ovf", ovf, 0);

    // Input gaps and output backpressure on channel 1
    begin_burst(4);
    send(1, 7); step();
    send(1, 8); step();
    send(2, 9); step();
    send(1, 3);
    for (int k = 0; k < 50; k++) begin
      if (out_valid && out_ch == 2'd1) break;
      step();
    end
    chk("bp_reached_ch1", out_ch, 1);
    out_ready = 1'b0;
    step(); step(); step();
    chk("bp_stalled_data", out_data, 18);
    out_ready = 1'b1;
    wait_done();
    step();
    chk_drain("bp", 0, 18, 9, 0);

    // start while busy must be ignored
    begin_burst(3);
    send(0, 50);
    start = 1'b1;
    len = 8'd7;
    send(1, 60);
    start = 1'b0;
    send(3, 70);
    for (int k = 0; k < 20; k++) begin
      if (out_valid) break;
      step();
    end
    start = 1'b1;
    step(); step();
    start = 1'b0;
    wait_done();
    step(); step();
    chk_drain("busy_start", 50, 60, 0, 70);
    chk("busy_start_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
